// File: rtl/pulse_cdc_scheduler.sv
// pulse_cdc_scheduler: round-robin scheduler sharing one pulse-synchronizer channel among NUM_REQ requesters
// Ports:
//   clk_i, rst_n_i   clock and asynchronous active-low reset
//   req_i            per-requester single-cycle event strobes
//   ack_i            return pulse from the far-domain synchronizer
//   clr_ovf_i        clears overflow_o
//   sync_pulse_o     single-cycle pulse into the synchronizer
//   sync_id_o        requester index of the current/last transfer
//   done_o           one-hot completion strobe
//   timeout_o        strobe when no ack arrived in time
//   pending_o        latched, not-yet-issued events
//   overflow_o       sticky flag: event merged into a pending one
//   busy_o           scheduler not idle
module pulse_cdc_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int MIN_GAP     = 3,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ack_i,
    input  logic               clr_ovf_i,
    output logic               sync_pulse_o,
    output logic [IDW-1:0]     sync_id_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic               timeout_o,
    output logic [NUM_REQ-1:0] pending_o,
    output logic [NUM_REQ-1:0] overflow_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     id_q, id_d, ptr_q, ptr_d, win;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0] pend_q, pend_d, ovf_q, ovf_d, done_q, done_d, clr;
    logic               pulse_q, pulse_d, tmo_q, tmo_d, busy_q, busy_d, found;

    // First pending requester at or after the round-robin pointer
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && pend_q[(int'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        pulse_d = 1'b0;
        tmo_d   = 1'b0;
        done_d  = '0;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = win;
                    ptr_d   = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    pulse_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                clr[id_q] = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // ack takes priority over an expiring counter
                if (ack_i || cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    done_d[id_q] = ack_i;
                    tmo_d        = !ack_i;
                    gap_d        = '0;
                    state_d      = (MIN_GAP == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                // The completion cycle is followed by MIN_GAP idle cycles
                state_d = (gap_q == 4'(MIN_GAP)) ? IDLE : GAP;
                gap_d   = gap_q + 4'd1;
            end
        endcase
        // A new request re-arms a slot even in the cycle it is being issued
        pend_d = (pend_q & ~clr) | req_i;
        ovf_d  = (clr_ovf_i ? '0 : ovf_q) | (req_i & pend_q & ~clr);
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            done_q  <= '0;
            pulse_q <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
        end
    end

    assign sync_pulse_o = pulse_q;
    assign sync_id_o    = id_q;
    assign done_o       = done_q;
    assign timeout_o    = tmo_q;
    assign pending_o    = pend_q;
    assign overflow_o   = ovf_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_pulse_cdc_scheduler.sv
// tb_pulse_cdc_scheduler: directed scoreboard bench for pulse_cdc_scheduler
module tb_pulse_cdc_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       ack = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       sync_pulse;
    logic [1:0] sync_id;
    logic [3:0] done;
    logic       timeout;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       busy;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {int kind; int cyc; int val;} evt_t;
    evt_t sb[$];

    pulse_cdc_scheduler dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .ack_i(ack), .clr_ovf_i(clr_ovf),
        .sync_pulse_o(sync_pulse), .sync_id_o(sync_id), .done_o(done), .timeout_o(timeout),
        .pending_o(pending), .overflow_o(overflow), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // kind: 0 = sync pulse (val = id), 1 = done (val = vector), 2 = timeout (val = id)
    task automatic expect_evt(int kind, int c, int val);
        sb.push_back('{kind, c, val});
    endtask

    task automatic sb_check(int kind, int val);
        evt_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_evt kind %0d val %0h @cyc %0d: got event expected none", kind, val, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                n_fail++;
                $display("FAIL evt: got kind %0d val %0h cyc %0d expected kind %0d val %0h cyc %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_pulse) sb_check(0, int'(sync_id));
            if (done != 4'b0) sb_check(1, int'(done));
            if (timeout) sb_check(2, int'(sync_id));
        end
    end

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_req(int c, logic [3:0] v, logic clr);
        at(c);
        req = v;
        clr_ovf = clr;
        @(posedge clk);
        #1;
        req = '0;
        clr_ovf = 1'b0;
    endtask

    task automatic send_ack(int c);
        at(c);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_pend"}, pending, 0);
        chk({nm, "_ovf"}, overflow, 0);
        chk({nm, "_id"}, sync_id, 0);
        chk({nm, "_outs"}, {sync_pulse, done, timeout}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, p;
        do_reset();
        chk_all_zero("reset");

        // Isolated request: pulse at +2, done one cycle after ack, busy drops at +11
        b = cyc + 2;
        expect_evt(0, b + 2, 0);
        expect_evt(1, b + 7, 1);
        send_req(b, 4'b0001, 1'b0);
        chk("t1_pend", pending, 4'b0001);
        at(b + 3);
        chk("t1_pend_clr", pending, 0);
        chk("t1_busy", busy, 1);
        send_ack(b + 6);
        at(b + 10);
        chk("t1_busy_gap", busy, 1);
        at(b + 11);
        chk("t1_busy_idle", busy, 0);

        // All four at once after reset: ids 0..3 in order
        do_reset();
        b = cyc + 2;
        for (int k = 0; k < 4; k++) begin
            expect_evt(0, b + 2 + 9 * k, k);
            expect_evt(1, b + 6 + 9 * k, 1 << k);
        end
        send_req(b, 4'b1111, 1'b0);
        chk("t2_pend", pending, 4'b1111);
        for (int k = 0; k < 4; k++) send_ack(b + 5 + 9 * k);
        at(b + 40);
        chk("t2_ovf", overflow, 0);
        chk("t2_busy", busy, 0);

        // Double request on id 2; overflow set wins over simultaneous clear
        b = cyc;
        expect_evt(0, b + 2, 2);
        expect_evt(1, b + 6, 4'b0100);
        send_req(b, 4'b0100, 1'b0);
        send_req(b + 1, 4'b0100, 1'b1);
        chk("t3_ovf_set", overflow, 4'b0100);
        send_ack(b + 5);
        send_req(b + 15, 4'b0000, 1'b1);
        chk("t3_ovf_clr", overflow, 0);
        chk("t3_pend", pending, 0);

        // Request in its own ISSUE cycle re-arms without overflow
        b = cyc + 4;
        expect_evt(0, b + 2, 0);
        expect_evt(1, b + 6, 1);
        expect_evt(0, b + 11, 0);
        expect_evt(1, b + 15, 1);
        send_req(b, 4'b0001, 1'b0);
        send_req(b + 2, 4'b0001, 1'b0);
        chk("t5_pend", pending, 4'b0001);
        chk("t5_ovf", overflow, 0);
        send_ack(b + 5);
        send_ack(b + 14);
        at(b + 20);
        chk("t5_busy", busy, 0);

        // Timeout 256 cycles after the pulse
        do_reset();
        b = cyc + 2;
        expect_evt(0, b + 2, 1);
        expect_evt(2, b + 258, 1);
        send_req(b, 4'b0010, 1'b0);
        at(b + 258);
        chk("t4_pend", pending, 0);
        chk("t4_tmo", timeout, 1);

        // Ack on the final wait cycle: done only
        p = b + 265;
        expect_evt(0, p + 2, 3);
        expect_evt(1, p + 258, 4'b1000);
        send_req(p, 4'b1000, 1'b0);
        send_ack(p + 257);
        at(p + 258);
        chk("t4_no_tmo", timeout, 0);
        send_ack(p + 265);
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_outs", {sync_pulse, done, timeout, pending}, 0);
        chk("idle_ack_id", sync_id, 3);

        // Reset mid-transaction, late ack ignored
        b = cyc + 2;
        expect_evt(0, b + 2, 2);
        send_req(b, 4'b0100, 1'b0);
        at(b + 4);
        chk("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_ack(b + 8);
        at(b + 12);
        chk_all_zero("t6");

        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
